// File: rtl/bs_dec_pkg.sv
// Shared types and arithmetic helpers for the bitstream decode/accumulate column.
package bs_dec_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} bs_dec_state_t;

  // Helpers work in a wide signed domain; callers size-cast back to their widths.
  localparam int CALC_W = 64;

  // Bipolar value of a window: each one counts +1, each zero counts -1.
  function automatic logic signed [CALC_W-1:0] bipolar_val(
    input logic [31:0] ones,
    input logic [31:0] len
  );
    logic signed [CALC_W-1:0] ones_s;
    logic signed [CALC_W-1:0] len_s;
    ones_s = $signed({32'd0, ones});
    len_s  = $signed({32'd0, len});
    return (ones_s <<< 1) - len_s;
  endfunction

  // Signed add clamped to the range of an accw-bit two's-complement register.
  function automatic logic signed [CALC_W-1:0] sat_add(
    input logic signed [CALC_W-1:0] acc,
    input logic signed [CALC_W-1:0] val,
    input int unsigned              accw
  );
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    sum   = acc + val;
    max_v = (64'sd1 <<< (accw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (accw - 1));
    if (sum > max_v) return max_v;
    if (sum < min_v) return min_v;
    return sum;
  endfunction

endpackage

// File: rtl/bs_dec_acc_sat_acc.sv
// Signed saturating accumulator with synchronous clear and a sticky saturation flag.
// A clear coincident with an add clears first, then adds the new value.
module sat_acc
  import bs_dec_pkg::*;
#(
  parameter int ACCW = 24,
  parameter int VALW = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_add,
  input  logic signed [VALW-1:0] i_val,
  output logic signed [ACCW-1:0] o_acc,
  output logic                   o_sat
);

  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic signed [CALC_W-1:0] base, val, sum, clamp;

  // Next accumulator value: optional clear, then optional clamped add.
  always_comb begin
    base  = i_clr ? '0 : CALC_W'(acc_q);
    val   = CALC_W'(i_val);
    sum   = base + val;
    clamp = sat_add(base, val, ACCW);
    acc_d = acc_q;
    sat_d = sat_q;
    if (i_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end
    if (i_add) begin
      acc_d = ACCW'(clamp);
      if (clamp != sum) sat_d = 1'b1;
    end
  end

  // Accumulator and sticky flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign o_acc = acc_q;
  assign o_sat = sat_q;

endmodule

// File: rtl/bs_dec_acc.sv
// Bipolar bitstream window decoder feeding a saturating column accumulator.
// Stream semantics: i_bit is consumed on every RUN cycle where i_bit_vld=1;
// there is no backpressure, gaps (i_bit_vld=0) simply stall the window.
module bs_dec_acc
  import bs_dec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACCW  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [WIDTH:0]          i_len,
  input  logic                    i_bit_vld,
  input  logic                    i_bit,
  input  logic                    i_clr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic signed [WIDTH+1:0] o_win,
  output logic signed [ACCW-1:0]  o_acc,
  output logic                    o_sat,
  output bs_dec_state_t           o_state
);

  bs_dec_state_t          state_q, state_d;
  logic [WIDTH:0]         remain_q, remain_d;
  logic [WIDTH:0]         ones_q, ones_d;
  logic [WIDTH:0]         len_q, len_d;
  logic                   done_q, done_d;
  logic signed [WIDTH+1:0] win_q, win_d;

  logic [WIDTH:0]          len_eff;
  logic [WIDTH:0]          ones_fin;
  logic signed [WIDTH+1:0] win_nxt;
  logic                    win_end;

  // Window datapath: effective length, final ones count and bipolar result.
  always_comb begin
    len_eff  = (i_len == '0) ? {1'b1, {WIDTH{1'b0}}} : i_len;
    win_end  = (state_q == RUN) && i_bit_vld && (remain_q == (WIDTH+1)'(1));
    ones_fin = ones_q + (WIDTH+1)'(i_bit);
    win_nxt  = (WIDTH+2)'(bipolar_val(32'(ones_fin), 32'(len_q)));
  end

  // FSM next state and counters; a start always wins over the finishing window's IDLE.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ones_d   = ones_q;
    len_d    = len_q;
    done_d   = 1'b0;
    win_d    = win_q;
    if ((state_q == RUN) && i_bit_vld) begin
      ones_d   = ones_fin;
      remain_d = remain_q - (WIDTH+1)'(1);
    end
    if (win_end) begin
      state_d = IDLE;
      done_d  = 1'b1;
      win_d   = win_nxt;
    end
    if (i_start) begin
      state_d  = RUN;
      remain_d = len_eff;
      len_d    = len_eff;
      ones_d   = '0;
    end
  end

  // State and window registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      ones_q   <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ones_q   <= ones_d;
      len_q    <= len_d;
      done_q   <= done_d;
      win_q    <= win_d;
    end
  end

  sat_acc #(
    .ACCW (ACCW),
    .VALW (WIDTH + 2)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (i_clr),
    .i_add (win_end),
    .i_val (win_nxt),
    .o_acc (o_acc),
    .o_sat (o_sat)
  );

  assign o_busy  = (state_q == RUN);
  assign o_done  = done_q;
  assign o_win   = win_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_bs_dec_acc.sv
// Directed bench for bs_dec_acc with a window-level reference model and scoreboard.
module tb_bs_dec_acc;
  import bs_dec_pkg::*;

  localparam int WIDTH   = 8;
  localparam int ACCW    = 10;
  localparam int ACC_MAX = (1 << (ACCW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACCW - 1));

  localparam int M_ONES   = 0;
  localparam int M_ZEROS  = 1;
  localparam int M_ALT    = 2;
  localparam int M_ONES12 = 3;
  localparam int M_RAND   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [WIDTH:0] i_len = '0;
  logic i_bit_vld = 1'b0;
  logic i_bit = 1'b0;
  logic i_clr = 1'b0;
  logic o_busy, o_done, o_sat;
  logic signed [WIDTH+1:0] o_win;
  logic signed [ACCW-1:0] o_acc;
  bs_dec_state_t o_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bs_dec_acc #(.WIDTH(WIDTH), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
    .i_bit_vld(i_bit_vld), .i_bit(i_bit), .i_clr(i_clr),
    .o_busy(o_busy), .o_done(o_done), .o_win(o_win), .o_acc(o_acc),
    .o_sat(o_sat), .o_state(o_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic signed [31:0] win;
    logic signed [31:0] acc;
    logic               sat;
    logic signed [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int m_acc = 0;
  bit m_sat = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every window result is compared when o_done fires; a late or missing done is flagged.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", longint'(o_done), 0);
        end else begin
          cur = exp_q.pop_front();
          chk("done_cycle", cyc, cur.cyc);
          chk("win", o_win, cur.win);
          chk("acc", o_acc, cur.acc);
          chk("sat", longint'(o_sat), longint'(cur.sat));
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        chk("missed_done_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit bit_for(input int mode, input int n);
    case (mode)
      M_ONES:   return 1'b1;
      M_ZEROS:  return 1'b0;
      M_ALT:    return (n % 2 == 0);
      M_ONES12: return (n < 12);
      default:  return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Window value feeds the running sum (cleared first if asked), clamped to ACCW bits.
  task automatic push_expect(input int win, input bit clr);
    exp_t e;
    if (clr) begin
      m_acc = 0;
      m_sat = 1'b0;
    end
    m_acc = m_acc + win;
    if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
    if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
    e.win = win;
    e.acc = m_acc;
    e.sat = m_sat;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input int len_field, input int mode, input int gap,
                             input bit clr_end, input bit start_end, input int next_len,
                             input bit skip_start, output int start_cyc);
    int len, cnt, ones, idx;
    bit b;
    len = (len_field == 0) ? (1 << WIDTH) : len_field;
    start_cyc = cyc;
    if (!skip_start) begin
      // A valid 1 in the start cycle must not be counted.
      i_start = 1'b1; i_len = (WIDTH+1)'(len_field); i_bit_vld = 1'b1; i_bit = 1'b1;
      tick();
      i_start = 1'b0;
    end
    cnt = 0; ones = 0; idx = 0;
    while (cnt < len) begin
      idx++;
      if (gap > 0 && idx % gap == 0) begin
        i_bit_vld = 1'b0;
        i_bit = 1'($urandom_range(0, 1));
      end else begin
        b = bit_for(mode, cnt);
        i_bit_vld = 1'b1;
        i_bit = b;
        ones += int'(b);
        cnt++;
        if (cnt == len) begin
          i_clr = clr_end;
          if (start_end) begin
            i_start = 1'b1;
            i_len = (WIDTH+1)'(next_len);
          end
          push_expect(2 * ones - len, clr_end);
        end
      end
      tick();
    end
    i_bit_vld = 1'b0; i_start = 1'b0; i_clr = 1'b0;
  endtask

  task automatic send_partial(input int len_field, input int nbits);
    i_start = 1'b1; i_len = (WIDTH+1)'(len_field); i_bit_vld = 1'b0;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      i_bit_vld = 1'b1; i_bit = 1'b1;
      tick();
    end
    i_bit_vld = 1'b0;
  endtask

  task automatic do_clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    m_acc = 0;
    m_sat = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int sc;
  int acc_seq[4] = '{256, 511, 511, 511};
  bit sat_seq[4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_win", o_win, 0);
    chk("rst_acc", o_acc, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_state", longint'(o_state), longint'(IDLE));
    rst_n = 1'b1;

    // Full-positive window, length field 0 means 256.
    send_window(0, M_ONES, 0, 1'b0, 1'b0, 0, 1'b0, sc);
    chk("t1_latency", cyc - sc, 257);
    chk("t1_done", o_done, 1);
    chk("t1_busy", o_busy, 0);
    chk("t1_win", o_win, 256);
    chk("t1_acc", o_acc, 256);
    tick();
    chk("t1_done_pulse", o_done, 0);
    chk("t1_win_held", o_win, 256);

    // Alternating bits leave the sum unchanged.
    send_window(256, M_ALT, 0, 1'b0, 1'b0, 0, 1'b0, sc);
    chk("t2a_win", o_win, 0);
    chk("t2a_acc", o_acc, 256);

    // Gapped stream, 12 ones of 16.
    send_window(16, M_ONES12, 3, 1'b0, 1'b0, 0, 1'b0, sc);
    chk("t2b_win", o_win, 8);
    chk("t2b_acc", o_acc, 264);

    // Restart after 5 bits, then 16 zeros.
    send_partial(16, 5);
    chk("t3a_busy", o_busy, 1);
    send_window(16, M_ZEROS, 0, 1'b0, 1'b0, 0, 1'b0, sc);
    chk("t3a_win", o_win, -16);
    chk("t3a_acc", o_acc, 248);

    // Reset mid-window.
    send_partial(16, 7);
    rst_n = 1'b0;
    tick();
    m_acc = 0; m_sat = 1'b0;
    chk("t3b_busy", o_busy, 0);
    chk("t3b_done", o_done, 0);
    chk("t3b_win", o_win, 0);
    chk("t3b_acc", o_acc, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t3b_idle_busy", o_busy, 0);

    // Saturation with a 10-bit accumulator.
    for (int w = 0; w < 4; w++) begin
      send_window(256, M_ONES, 0, 1'b0, 1'b0, 0, 1'b0, sc);
      chk("t4_acc", o_acc, acc_seq[w]);
      chk("t4_sat", o_sat, sat_seq[w]);
    end
    do_clr();
    chk("t4_clr_acc", o_acc, 0);
    chk("t4_clr_sat", o_sat, 0);

    // Clear coincident with window end: clear, then add.
    send_window(100, M_ONES, 0, 1'b0, 1'b0, 0, 1'b0, sc);
    chk("t5a_pre_acc", o_acc, 100);
    send_window(4, M_ZEROS, 0, 1'b1, 1'b0, 0, 1'b0, sc);
    chk("t5a_win", o_win, -4);
    chk("t5a_acc", o_acc, -4);

    // Start coincident with window end: busy stays high, next result stacks.
    send_window(8, M_ONES, 2, 1'b0, 1'b1, 6, 1'b0, sc);
    chk("t5b_done", o_done, 1);
    chk("t5b_busy", o_busy, 1);
    chk("t5b_win", o_win, 8);
    chk("t5b_acc", o_acc, 4);
    send_window(6, M_ONES, 0, 1'b0, 1'b0, 0, 1'b1, sc);
    chk("t5b_next_win", o_win, 6);
    chk("t5b_next_acc", o_acc, 10);

    // Shortest window and a random gapped window, checked against the model.
    send_window(1, M_ONES, 0, 1'b0, 1'b0, 0, 1'b0, sc);
    chk("len1_win", o_win, 1);
    send_window(37, M_RAND, 4, 1'b0, 1'b0, 0, 1'b0, sc);
    send_window(200, M_RAND, 5, 1'b0, 1'b0, 0, 1'b0, sc);

    repeat (5) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
